mm_handshake: RTL and testbench

- Word-addressed data/instruction memory with a fixed, parameterised access latency and a Req/Busy/Done handshake.
- It replaces the zero-latency combinational main memory on the multi-cycle CPU's memory port.
- The control unit raises Req with an address and a read/write command, then holds its state until Done.
- The block lets the control sequencer be exercised against realistic wait states.

---
 rtl/mm_handshake_pkg.sv | 22 ++
 rtl/mm_handshake_if.sv | 29 ++
 rtl/mm_handshake_word_array.sv | 38 +++
 rtl/mm_handshake.sv | 114 +++++++++++
 tb/tb_mm_handshake.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mm_handshake_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mm_handshake_pkg
//  Brief    : Shared command/state encodings for the wait-state memory port.
//  Revision : 1.0
// ============================================================================
package mm_handshake_pkg;

    localparam int LAT_W = 4;

    localparam logic [1:0] MM_NOP   = 2'b00;
    localparam logic [1:0] MM_READ  = 2'b01;
    localparam logic [1:0] MM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mm_state_t;

endpackage
`default_nettype wire

// File: rtl/mm_handshake_if.sv
`default_nettype none
// ============================================================================
//  Module   : mm_handshake_if
//  Brief    : Req/Busy/Done memory port between control unit and memory.
//  Revision : 1.0
// ============================================================================
interface mm_handshake_if;

    logic        Req;
    logic [1:0]  Ctrl;
    logic [31:0] Addr;
    logic [31:0] W_data;
    logic [31:0] R_data;
    logic        Busy;
    logic        Done;
    logic        Err;

    modport master (
        output Req, Ctrl, Addr, W_data,
        input  R_data, Busy, Done, Err
    );

    modport slave (
        input  Req, Ctrl, Addr, W_data,
        output R_data, Busy, Done, Err
    );

endinterface
`default_nettype wire

// File: rtl/mm_handshake_word_array.sv
`default_nettype none
// ============================================================================
//  Module   : mm_word_array
//  Brief    : 2^DEPTH_LOG2 x 32 synchronous word store, one write port and a
//             registered read port that holds until the next read enable.
//  Revision : 1.0
// ============================================================================
module mm_word_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    input  wire logic                  i_we,
    input  wire logic                  i_re,
    input  wire logic [DEPTH_LOG2-1:0] i_addr,
    input  wire logic [31:0]           i_wdata,
    output logic [31:0]                o_rdata
);

    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= 32'h0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : mm_handshake
//  Brief    : Word memory with fixed access latency behind a Req/Busy/Done
//             handshake; flags misaligned or out-of-range accesses with Err.
//  Revision : 1.0
// ============================================================================
module mm_handshake
    import mm_handshake_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  wire logic      CLK,
    input  wire logic      RST,
    mm_handshake_if.slave  bus
);

    localparam logic [LAT_W-1:0] c_lat_load = LAT_W'(LATENCY - 1);

    mm_state_t             r_state;
    logic [LAT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic                  r_is_write;
    logic                  r_bad;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_addr_bad;
    logic                  w_complete;
    logic                  w_we;
    logic                  w_re;
    logic [31:0]           w_rdata;

    assign w_accept   = bus.Req && ((bus.Ctrl == MM_READ) || (bus.Ctrl == MM_WRITE));
    assign w_addr_bad = (bus.Addr[1:0] != 2'b00) || (|bus.Addr[31:DEPTH_LOG2+2]);

    // The access edge is also gated by RST so an abort never commits a write.
    assign w_complete = (r_state == ST_WAIT) && (r_cnt == '0) && !r_bad && !RST;
    assign w_we       = w_complete && r_is_write;
    assign w_re       = w_complete && !r_is_write;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= 32'h0;
            r_is_write <= 1'b0;
            r_bad      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_accept) begin
                        r_idx      <= bus.Addr[DEPTH_LOG2+1:2];
                        r_wdata    <= bus.W_data;
                        r_is_write <= (bus.Ctrl == MM_WRITE);
                        r_bad      <= w_addr_bad;
                        r_cnt      <= c_lat_load;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Busy rises on the first edge after acceptance.
                    r_busy <= 1'b1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - LAT_W'(1);
                    end else begin
                        r_done  <= 1'b1;
                        r_err   <= r_bad;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mm_word_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.R_data = w_rdata;
    assign bus.Busy   = r_busy;
    assign bus.Done   = r_done;
    assign bus.Err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mm_handshake.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_handshake
//  Brief    : Bench for mm_handshake at LATENCY=3 and LATENCY=1 against a
//             word-array reference model.
//  Revision : 1.0
// ============================================================================
module tb_mm_handshake;
    import mm_handshake_pkg::*;

    localparam int DL    = 8;
    localparam int NW    = 1 << DL;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        sel   = 1'b0;
    logic [1:0]  ctrl  = 2'b00;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;

    int total = 0;
    int bad   = 0;

    mm_handshake_if ifa ();
    mm_handshake_if ifb ();

    assign ifa.Req    = req & ~sel;
    assign ifa.Ctrl   = ctrl;
    assign ifa.Addr   = addr;
    assign ifa.W_data = wdata;
    assign ifb.Req    = req & sel;
    assign ifb.Ctrl   = ctrl;
    assign ifb.Addr   = addr;
    assign ifb.W_data = wdata;

    mm_handshake #(.DEPTH_LOG2(DL), .LATENCY(LAT_A)) dut_a (
        .CLK (clk), .RST (rst), .bus (ifa)
    );
    mm_handshake #(.DEPTH_LOG2(DL), .LATENCY(LAT_B)) dut_b (
        .CLK (clk), .RST (rst), .bus (ifb)
    );

    wire [34:0] obs = sel ? {ifb.Busy, ifb.Done, ifb.Err, ifb.R_data}
                          : {ifa.Busy, ifa.Done, ifa.Err, ifa.R_data};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference model: one word array and one read-data latch per DUT.
    logic [31:0] mem_m [2][NW];
    logic [31:0] rd_m  [2];

    function automatic logic [31:0] initv(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DL + 2)) != 32'h0);
    endfunction

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request from a negedge; returns at the negedge of the first
    // IDLE cycle after completion. Status is compared every cycle.
    task automatic run_txn(input bit s, input logic [1:0] c, input logic [31:0] a,
                           input logic [31:0] d, input bit intrude,
                           output logic e_o, output logic [31:0] rd_o);
        int lat;
        bit valid;
        bit badf;
        int idx;
        logic [34:0] exp;
        lat   = s ? LAT_B : LAT_A;
        valid = (c == MM_READ) || (c == MM_WRITE);
        badf  = is_bad(a);
        idx   = int'((a >> 2) & 32'(NW - 1));
        sel = s; ctrl = c; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1;
        req   = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        e_o   = 1'b0;
        rd_o  = 32'h0;
        if (!valid) begin
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                check("noop_status", obs, {3'b000, rd_m[s]});
                e_o  = obs[32];
                rd_o = obs[31:0];
            end
            return;
        end
        for (int j = 0; j <= lat + 1; j++) begin
            @(negedge clk);
            if (j == lat && !badf) begin
                if (c == MM_WRITE) mem_m[s][idx] = d;
                else               rd_m[s] = mem_m[s][idx];
            end
            exp = {(j >= 1 && j <= lat), (j == lat), (j == lat && badf), rd_m[s]};
            check(s ? "cycle_lat1" : "cycle_lat3", obs, exp);
            if (j == lat) begin
                e_o  = obs[32];
                rd_o = obs[31:0];
            end
            if (intrude && j == 1) begin
                req = 1'b1; ctrl = MM_WRITE; addr = 32'h20; wdata = 32'hBAD0BAD0;
            end
            if (intrude && j == lat + 1) req = 1'b0;
        end
    endtask

    typedef struct {
        bit          s;
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;
    } vec_t;

    vec_t        tbl [12];
    logic        e_r;
    logic [31:0] rd_r;

    initial begin
        tbl[0]  = '{1'b0, MM_WRITE, 32'h10,  32'hDEADBEEF, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b0, MM_READ,  32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, MM_WRITE, 32'h14,  32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, MM_READ,  32'h12,  32'h0,        1'b1, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, MM_READ,  32'h400, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, MM_WRITE, 32'h11,  32'h11111111, 1'b1, 32'hDEADBEEF};
        tbl[6]  = '{1'b0, MM_WRITE, 32'h400, 32'h22222222, 1'b1, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, MM_READ,  32'h14,  32'h0,        1'b0, 32'hCAFEF00D};
        tbl[8]  = '{1'b0, MM_READ,  32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[9]  = '{1'b0, 2'b11,    32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b0, MM_READ,  32'h0,   32'h0,        1'b0, 32'h5A5A0000};
        tbl[11] = '{1'b1, MM_READ,  32'h4,   32'h0,        1'b0, 32'hC46D79B9};

        rd_m[0] = 32'h0;
        rd_m[1] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", {ifa.Busy, ifa.Done, ifa.Err, ifa.R_data}, 35'h0);
        check("reset_b", {ifb.Busy, ifb.Done, ifb.Err, ifb.R_data}, 35'h0);
        rst = 1'b0;

        // Fill both arrays with known contents so every later read is checkable.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NW; i++) begin
                run_txn(s[0], MM_WRITE, 32'(i) << 2, initv(i), 1'b0, e_r, rd_r);
            end
        end

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].s, tbl[i].c, tbl[i].a, tbl[i].d, 1'b0, e_r, rd_r);
            check($sformatf("tbl%0d_err", i), {34'h0, e_r}, {34'h0, tbl[i].e});
            check($sformatf("tbl%0d_rdata", i), {3'b000, rd_r}, {3'b000, tbl[i].rd});
        end

        // A write presented during WAIT must be dropped entirely.
        run_txn(1'b0, MM_READ, 32'h10, 32'h0, 1'b1, e_r, rd_r);
        @(negedge clk);
        check("no_second_done", obs, {3'b000, rd_m[0]});
        run_txn(1'b0, MM_READ, 32'h20, 32'h0, 1'b0, e_r, rd_r);
        check("word8_unchanged", {3'b000, rd_r}, {3'b000, initv(8)});

        // Reset lands on the completion edge of a write: nothing is committed.
        sel = 1'b0; ctrl = MM_WRITE; addr = 32'h30; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_a", {ifa.Busy, ifa.Done, ifa.Err, ifa.R_data}, 35'h0);
        check("abort_b_rdata", {3'b000, ifb.R_data}, 35'h0);
        rst = 1'b0;
        rd_m[0] = 32'h0;
        rd_m[1] = 32'h0;
        run_txn(1'b0, MM_READ, 32'h30, 32'h0, 1'b0, e_r, rd_r);
        check("abort_old_word", {3'b000, rd_r}, {3'b000, initv(12)});

        // Back-to-back reads on the LATENCY=1 instance, one per IDLE cycle.
        for (int n = 0; n < 16; n++) begin
            run_txn(1'b1, MM_READ, 32'($urandom_range(0, NW - 1)) << 2, 32'h0, 1'b0, e_r, rd_r);
        end

        for (int n = 0; n < 80; n++) begin
            logic [31:0] ra;
            int          kind;
            kind = $urandom_range(0, 9);
            ra   = 32'($urandom_range(0, NW - 1)) << 2;
            if (kind == 7)      ra = ra | 32'($urandom_range(1, 3));
            else if (kind >= 8) ra = $urandom;
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                    1'b0, e_r, rd_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
